// File: rtl/usb_consts_pkg.sv
// +----------------------------------------------------------------------------+
// | usb_consts_pkg: shared constants and endpoint state type for the IN sched  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package usb_consts_pkg;
  localparam int NumInEps         = 12;
  localparam int MaxInPktSizeByte = 64;
  localparam int NumBufs          = 32;
  localparam int MaxRetries       = 3;

  typedef enum logic [1:0] {
    EpIdle  = 2'd0,
    EpReady = 2'd1,
    EpBusy  = 2'd2
  } in_sched_ep_state_e;
endpackage

`default_nettype wire

// File: rtl/usb_fs_nb_in_sched_ep.sv
// +----------------------------------------------------------------------------+
// | usb_fs_nb_in_sched_ep: per-endpoint arm/busy FSM with buffer id and size   |
// | Optional: USB_IN_SCHED_RETRY_LIMIT_EN bounds rollbacks per packet          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_fs_nb_in_sched_ep
  import usb_consts_pkg::*;
#(
  parameter int BufW = 5,
  parameter int PktW = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            link_reset_i,
  input  logic            cfg_we_i,
  input  logic            cfg_rdy_i,
  input  logic [BufW-1:0] cfg_buf_i,
  input  logic [PktW:0]   cfg_size_i,
  input  logic            start_i,
  input  logic            end_i,
  input  logic            rollback_i,
  output logic            has_data_o,
  output logic            busy_o,
  output logic [BufW-1:0] buf_o,
  output logic [PktW:0]   size_o,
  output logic            arm_o,
  output logic            pend_set_o,
  output logic            sent_set_o,
  output logic            err_o
);

  in_sched_ep_state_e state_q, state_d;
  logic [BufW-1:0]    buf_q, buf_d;
  logic [PktW:0]      size_q, size_d;
  logic               retry_exhausted;

`ifdef USB_IN_SCHED_RETRY_LIMIT_EN
  localparam logic [1:0] RetryMax = 2'(MaxRetries);
  logic [1:0] retry_q, retry_d;

  assign retry_exhausted = (retry_q == RetryMax);

  always_comb begin
    retry_d = retry_q;
    if (arm_o || sent_set_o) begin
      retry_d = '0;
    end else if (state_q == EpBusy && rollback_i && !end_i && !link_reset_i) begin
      retry_d = retry_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) retry_q <= '0;
    else         retry_q <= retry_d;
  end
`else
  assign retry_exhausted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    size_d     = size_q;
    arm_o      = 1'b0;
    pend_set_o = 1'b0;
    sent_set_o = 1'b0;
    err_o      = 1'b0;
    if (link_reset_i) begin
      if (state_q != EpIdle) begin
        state_d    = EpIdle;
        pend_set_o = 1'b1;
      end
    end else begin
      unique case (state_q)
        EpIdle: begin
          if (cfg_we_i && cfg_rdy_i) begin
            state_d = EpReady;
            buf_d   = cfg_buf_i;
            size_d  = cfg_size_i;
            arm_o   = 1'b1;
          end
        end
        EpReady: begin
          // A starting transaction locks the buffer before a racing write lands.
          if (start_i) begin
            state_d = EpBusy;
            err_o   = cfg_we_i;
          end else if (cfg_we_i && cfg_rdy_i) begin
            buf_d  = cfg_buf_i;
            size_d = cfg_size_i;
            arm_o  = 1'b1;
          end else if (cfg_we_i) begin
            state_d    = EpIdle;
            pend_set_o = 1'b1;
          end
        end
        EpBusy: begin
          err_o = cfg_we_i;
          if (end_i) begin
            state_d    = EpIdle;
            sent_set_o = 1'b1;
          end else if (rollback_i) begin
            if (retry_exhausted) begin
              state_d    = EpIdle;
              pend_set_o = 1'b1;
            end else begin
              state_d = EpReady;
            end
          end
        end
        default: state_d = EpIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EpIdle;
      buf_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      size_q  <= size_d;
    end
  end

  assign has_data_o = (state_q != EpIdle);
  assign busy_o     = (state_q == EpBusy);
  assign buf_o      = buf_q;
  assign size_o     = size_q;

endmodule

`default_nettype wire

// File: rtl/usb_fs_nb_in_sched.sv
// +----------------------------------------------------------------------------+
// | usb_fs_nb_in_sched: buffer supply sequencer for the non-buffered IN engine |
// | Optional: USB_IN_SCHED_RETRY_LIMIT_EN (see usb_fs_nb_in_sched_ep)          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_fs_nb_in_sched
  import usb_consts_pkg::*;
#(
  parameter int NumInEps         = usb_consts_pkg::NumInEps,
  parameter int MaxInPktSizeByte = usb_consts_pkg::MaxInPktSizeByte,
  parameter int NumBufs          = usb_consts_pkg::NumBufs,
  localparam int PktW            = $clog2(MaxInPktSizeByte),
  localparam int BufW            = $clog2(NumBufs)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_ep_i,
  input  logic [BufW-1:0]      cfg_buf_i,
  input  logic [PktW:0]        cfg_size_i,
  input  logic                 cfg_rdy_i,
  output logic                 cfg_err_o,
  input  logic [NumInEps-1:0]  sent_clr_i,
  input  logic                 in_xact_starting_i,
  input  logic [3:0]           in_xact_start_ep_i,
  input  logic [3:0]           in_ep_current_i,
  input  logic                 in_ep_rollback_i,
  input  logic                 in_ep_xact_end_i,
  input  logic [PktW-1:0]      in_ep_get_addr_i,
  output logic [NumInEps-1:0]  in_ep_has_data_o,
  output logic [NumInEps-1:0]  in_ep_data_done_o,
  output logic [7:0]           in_ep_data_o,
  output logic                 mem_req_o,
  output logic [BufW+PktW-3:0] mem_addr_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [NumInEps-1:0]  rdy_o,
  output logic [NumInEps-1:0]  pkt_sent_o,
  output logic [NumInEps-1:0]  pend_o
);

  localparam logic [4:0]    NumEpsL = 5'(NumInEps);
  localparam logic [PktW:0] MaxSize = (PktW+1)'(MaxInPktSizeByte);

  logic                cfg_ok;
  logic [NumInEps-1:0] ep_arm, ep_pend_set, ep_sent_set, ep_err, ep_busy;
  logic [BufW-1:0]     ep_buf  [NumInEps];
  logic [PktW:0]       ep_size [NumInEps];
  logic [NumInEps-1:0] pend_q, pend_d, sent_q, sent_d;
  logic                err_q, err_d;
  logic [1:0]          lane_q;
  logic [BufW-1:0]     cur_buf;
  logic                cur_busy;

  assign cfg_ok = ({1'b0, cfg_ep_i} < NumEpsL) && (cfg_size_i <= MaxSize);

  for (genvar g = 0; g < NumInEps; g++) begin : g_ep
    usb_fs_nb_in_sched_ep #(
      .BufW (BufW),
      .PktW (PktW)
    ) u_ep (
      .clk_i        (clk_48mhz_i),
      .rst_ni       (rst_ni),
      .link_reset_i (link_reset_i),
      .cfg_we_i     (cfg_we_i && cfg_ok && (cfg_ep_i == 4'(g))),
      .cfg_rdy_i    (cfg_rdy_i),
      .cfg_buf_i    (cfg_buf_i),
      .cfg_size_i   (cfg_size_i),
      .start_i      (in_xact_starting_i && (in_xact_start_ep_i == 4'(g))),
      .end_i        (in_ep_xact_end_i && (in_ep_current_i == 4'(g))),
      .rollback_i   (in_ep_rollback_i && (in_ep_current_i == 4'(g))),
      .has_data_o   (in_ep_has_data_o[g]),
      .busy_o       (ep_busy[g]),
      .buf_o        (ep_buf[g]),
      .size_o       (ep_size[g]),
      .arm_o        (ep_arm[g]),
      .pend_set_o   (ep_pend_set[g]),
      .sent_set_o   (ep_sent_set[g]),
      .err_o        (ep_err[g])
    );

    // Sizes of MaxInPktSizeByte never compare done; the engine ends on address wrap.
    assign in_ep_data_done_o[g] = in_ep_has_data_o[g] && (in_ep_current_i == 4'(g)) &&
                                  ({1'b0, in_ep_get_addr_i} >= ep_size[g]);
  end

  always_comb begin
    cur_buf  = '0;
    cur_busy = 1'b0;
    for (int i = 0; i < NumInEps; i++) begin
      if (in_ep_current_i == 4'(i)) begin
        cur_buf  = ep_buf[i];
        cur_busy = ep_busy[i];
      end
    end
  end

  assign err_d  = cfg_we_i && (!cfg_ok || (|ep_err));
  assign pend_d = (pend_q & ~ep_arm) | ep_pend_set;
  assign sent_d = (sent_q & ~sent_clr_i) | ep_sent_set;

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      sent_q <= '0;
      err_q  <= 1'b0;
      lane_q <= '0;
    end else begin
      pend_q <= pend_d;
      sent_q <= sent_d;
      err_q  <= err_d;
      lane_q <= in_ep_get_addr_i[1:0];
    end
  end

  assign mem_req_o    = cur_busy;
  assign mem_addr_o   = {cur_buf, in_ep_get_addr_i[PktW-1:2]};
  assign in_ep_data_o = mem_rdata_i[{lane_q, 3'b000} +: 8];
  assign rdy_o        = in_ep_has_data_o;
  assign pkt_sent_o   = sent_q;
  assign pend_o       = pend_q;
  assign cfg_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_fs_nb_in_sched.sv
// +----------------------------------------------------------------------------+
// | tb_usb_fs_nb_in_sched: directed bench for the IN buffer scheduler          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_usb_fs_nb_in_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_reset;
  logic        cfg_we;
  logic [3:0]  cfg_ep;
  logic [4:0]  cfg_buf;
  logic [6:0]  cfg_size;
  logic        cfg_rdy;
  logic        cfg_err;
  logic [11:0] sent_clr;
  logic        xact_starting;
  logic [3:0]  xact_start_ep;
  logic [3:0]  ep_current;
  logic        rollback;
  logic        xact_end;
  logic [5:0]  get_addr;
  logic [11:0] has_data, data_done, rdy, pkt_sent, pend;
  logic [7:0]  data;
  logic        mem_req;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  usb_fs_nb_in_sched dut (
    .clk_48mhz_i        (clk),
    .rst_ni             (rst_n),
    .link_reset_i       (link_reset),
    .cfg_we_i           (cfg_we),
    .cfg_ep_i           (cfg_ep),
    .cfg_buf_i          (cfg_buf),
    .cfg_size_i         (cfg_size),
    .cfg_rdy_i          (cfg_rdy),
    .cfg_err_o          (cfg_err),
    .sent_clr_i         (sent_clr),
    .in_xact_starting_i (xact_starting),
    .in_xact_start_ep_i (xact_start_ep),
    .in_ep_current_i    (ep_current),
    .in_ep_rollback_i   (rollback),
    .in_ep_xact_end_i   (xact_end),
    .in_ep_get_addr_i   (get_addr),
    .in_ep_has_data_o   (has_data),
    .in_ep_data_done_o  (data_done),
    .in_ep_data_o       (data),
    .mem_req_o          (mem_req),
    .mem_addr_o         (mem_addr),
    .mem_rdata_i        (mem_rdata),
    .rdy_o              (rdy),
    .pkt_sent_o         (pkt_sent),
    .pend_o             (pend)
  );

  // RAM: byte lane l of word a holds (4*a + l) mod 256.
  always @(posedge clk) begin
    mem_rdata <= {8'(mem_addr * 4 + 3), 8'(mem_addr * 4 + 2),
                  8'(mem_addr * 4 + 1), 8'(mem_addr * 4)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] ep, input logic [4:0] b,
                           input logic [6:0] sz, input logic r);
    cfg_we = 1'b1; cfg_ep = ep; cfg_buf = b; cfg_size = sz; cfg_rdy = r;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_ep(input logic [3:0] ep);
    xact_starting = 1'b1; xact_start_ep = ep; ep_current = ep;
    tick();
    xact_starting = 1'b0;
  endtask

  task automatic end_xact();
    xact_end = 1'b1;
    tick();
    xact_end = 1'b0;
  endtask

  task automatic roll_xact();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; link_reset = 0; cfg_we = 0; cfg_ep = 0; cfg_buf = 0; cfg_size = 0;
    cfg_rdy = 0; sent_clr = 0; xact_starting = 0; xact_start_ep = 0; ep_current = 0;
    rollback = 0; xact_end = 0; get_addr = 0;
    repeat (3) tick();
    n_chk++; if ({rdy, pend, pkt_sent, data_done} !== 48'h0) begin
      n_fail++; $display("FAIL reset_status: got %h want 0", {rdy, pend, pkt_sent, data_done});
    end
    n_chk++; if ({cfg_err, mem_req, mem_addr, data} !== 19'h0) begin
      n_fail++; $display("FAIL reset_datapath: got %h want 0", {cfg_err, mem_req, mem_addr, data});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    cfg_write(4'd1, 5'd5, 7'd3, 1'b1);
    n_chk++; if (rdy !== 12'h002 || has_data !== 12'h002) begin
      n_fail++; $display("FAIL arm_ep1: rdy %h has_data %h want 002", rdy, has_data);
    end
    start_ep(4'd1);
    get_addr = 6'd0; #1;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 9'h050) begin
      n_fail++; $display("FAIL ep1_addr: req %b addr %h want 1 050", mem_req, mem_addr);
    end
    tick();
    n_chk++; if (data !== 8'h40) begin
      n_fail++; $display("FAIL ep1_byte0: got %h want 40", data);
    end
    get_addr = 6'd1; tick();
    n_chk++; if (data !== 8'h41) begin
      n_fail++; $display("FAIL ep1_byte1: got %h want 41", data);
    end
    get_addr = 6'd2; tick();
    n_chk++; if (data !== 8'h42 || data_done !== 12'h000) begin
      n_fail++; $display("FAIL ep1_byte2: data %h done %h want 42 000", data, data_done);
    end
    get_addr = 6'd3; #1;
    n_chk++; if (data_done !== 12'h002) begin
      n_fail++; $display("FAIL ep1_done: got %h want 002", data_done);
    end
    end_xact();
    n_chk++; if (pkt_sent !== 12'h002 || rdy !== 12'h000 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL ep1_sent: sent %h rdy %h req %b want 002 000 0", pkt_sent, rdy, mem_req);
    end
  endtask

  task automatic test_zlp();
    cfg_write(4'd2, 5'd3, 7'd0, 1'b1);
    start_ep(4'd2);
    get_addr = 6'd0; #1;
    n_chk++; if (data_done !== 12'h004) begin
      n_fail++; $display("FAIL zlp_done: got %h want 004", data_done);
    end
    end_xact();
    n_chk++; if (pkt_sent !== 12'h006) begin
      n_fail++; $display("FAIL zlp_sent: got %h want 006", pkt_sent);
    end
  endtask

  task automatic test_rollback();
    cfg_write(4'd3, 5'd7, 7'd4, 1'b1);
    start_ep(4'd3);
    get_addr = 6'd2;
    roll_xact();
    n_chk++; if (rdy !== 12'h008 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rollback_rearm: rdy %h req %b want 008 0", rdy, mem_req);
    end
    start_ep(4'd3);
    get_addr = 6'd0; #1;
    n_chk++; if (mem_addr !== 9'h070 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rollback_buf: addr %h req %b want 070 1", mem_addr, mem_req);
    end
    end_xact();
    n_chk++; if (pkt_sent !== 12'h00E) begin
      n_fail++; $display("FAIL rollback_sent: got %h want 00E", pkt_sent);
    end
  endtask

  task automatic test_sent_clr();
    cfg_write(4'd1, 5'd5, 7'd3, 1'b1);
    start_ep(4'd1);
    xact_end = 1'b1; sent_clr = 12'h00E;
    tick();
    xact_end = 1'b0; sent_clr = 12'h000;
    n_chk++; if (pkt_sent !== 12'h002) begin
      n_fail++; $display("FAIL sent_clr_race: got %h want 002", pkt_sent);
    end
  endtask

  task automatic test_busy_reject();
    cfg_write(4'd4, 5'd9, 7'd8, 1'b1);
    start_ep(4'd4);
    cfg_write(4'd4, 5'd1, 7'd2, 1'b1);
    n_chk++; if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL busy_err: got %b want 1", cfg_err);
    end
    tick();
    n_chk++; if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL busy_err_pulse: got %b want 0", cfg_err);
    end
    get_addr = 6'd7; #1;
    n_chk++; if (mem_addr !== 9'h091 || data_done !== 12'h000) begin
      n_fail++; $display("FAIL busy_locked: addr %h done %h want 091 000", mem_addr, data_done);
    end
    cfg_write(4'd12, 5'd1, 7'd1, 1'b1);
    n_chk++; if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_ep_err: got %b want 1", cfg_err);
    end
    cfg_write(4'd0, 5'd1, 7'd65, 1'b1);
    n_chk++; if (cfg_err !== 1'b1 || rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL oversize_err: err %b rdy0 %b want 1 0", cfg_err, rdy[0]);
    end
    end_xact();
    n_chk++; if (pkt_sent !== 12'h012 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL ep4_sent: sent %h err %b want 012 0", pkt_sent, cfg_err);
    end
    // Write racing the transaction start on ep8.
    cfg_write(4'd8, 5'd2, 7'd4, 1'b1);
    cfg_we = 1'b1; cfg_ep = 4'd8; cfg_buf = 5'd6; cfg_size = 7'd1; cfg_rdy = 1'b1;
    start_ep(4'd8);
    cfg_we = 1'b0;
    get_addr = 6'd0; #1;
    n_chk++; if (cfg_err !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 9'h020) begin
      n_fail++; $display("FAIL start_race: err %b req %b addr %h want 1 1 020", cfg_err, mem_req, mem_addr);
    end
    end_xact();
    n_chk++; if (pkt_sent !== 12'h112) begin
      n_fail++; $display("FAIL ep8_sent: got %h want 112", pkt_sent);
    end
  endtask

  task automatic test_withdraw();
    cfg_write(4'd7, 5'd4, 7'd10, 1'b1);
    cfg_write(4'd7, 5'd4, 7'd10, 1'b0);
    n_chk++; if (rdy !== 12'h000 || pend !== 12'h080 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL withdraw: rdy %h pend %h err %b want 000 080 0", rdy, pend, cfg_err);
    end
    cfg_write(4'd7, 5'd4, 7'd10, 1'b1);
    n_chk++; if (rdy !== 12'h080 || pend !== 12'h000) begin
      n_fail++; $display("FAIL rearm_pend: rdy %h pend %h want 080 000", rdy, pend);
    end
  endtask

  task automatic test_link_reset();
    cfg_write(4'd0, 5'd10, 7'd5, 1'b1);
    cfg_write(4'd5, 5'd11, 7'd6, 1'b1);
    n_chk++; if (rdy !== 12'h0A1) begin
      n_fail++; $display("FAIL pre_link_reset: got %h want 0A1", rdy);
    end
    link_reset = 1'b1;
    tick();
    link_reset = 1'b0;
    n_chk++; if (rdy !== 12'h000 || pend !== 12'h0A1 || pkt_sent !== 12'h112) begin
      n_fail++; $display("FAIL link_reset: rdy %h pend %h sent %h want 000 0A1 112", rdy, pend, pkt_sent);
    end
  endtask

  task automatic test_retry();
    cfg_write(4'd6, 5'd12, 7'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start_ep(4'd6);
      roll_xact();
    end
    n_chk++; if (rdy[6] !== 1'b1 || pend[6] !== 1'b0) begin
      n_fail++; $display("FAIL retry3: rdy6 %b pend6 %b want 1 0", rdy[6], pend[6]);
    end
    start_ep(4'd6);
    roll_xact();
`ifdef USB_IN_SCHED_RETRY_LIMIT_EN
    n_chk++; if (rdy[6] !== 1'b0 || pend[6] !== 1'b1) begin
      n_fail++; $display("FAIL retry_limit: rdy6 %b pend6 %b want 0 1", rdy[6], pend[6]);
    end
`else
    n_chk++; if (rdy[6] !== 1'b1 || pend[6] !== 1'b0) begin
      n_fail++; $display("FAIL retry_unlimited: rdy6 %b pend6 %b want 1 0", rdy[6], pend[6]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zlp();
    test_rollback();
    test_sent_clr();
    test_busy_reject();
    test_withdraw();
    test_link_reset();
    test_retry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
